// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared state encoding and Ethernet length constants for the tx arbiter
package eth_tx_pkg;
  localparam int ETH_MIN_PAYLOAD = 60;
  localparam int ETH_MAX_PAYLOAD = 1514;
  localparam int CNT_W = 11;
  typedef logic [4:0] state_t;
  localparam state_t ST_IDLE  = 5'b00001;
  localparam state_t ST_GRANT = 5'b00010;
  localparam state_t ST_SEND  = 5'b00100;
  localparam state_t ST_PAD   = 5'b01000;
  localparam state_t ST_WAIT  = 5'b10000;
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin picker, first set req at or after ptr with wrap-around
module rr_select #(
  parameter int N = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  // scan from the farthest offset down so the nearest requester overwrites the rest
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin sharing of the RGMII tx byte path between frame sources,
// with zero-padding to MIN_LEN, truncation at MAX_LEN and hold-off until the sender is idle.
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MIN_LEN = ETH_MIN_PAYLOAD,
  parameter int MAX_LEN = ETH_MAX_PAYLOAD,
  parameter int TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [8*NUM_REQ-1:0] in_data,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  input  logic                 tx_active,
  output logic                 busy,
  output logic                 truncated,
  output logic                 timed_out
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, next;
  logic [IW-1:0] rr_ptr, gidx, sel_idx, gnext;
  logic [NUM_REQ-1:0] sel_gnt;
  logic sel_any, seen, vin, last, short_frame, pad_done, expired;
  logic [7:0] din;
  logic [CNT_W-1:0] byte_cnt;
  logic [TW-1:0] timer;
  rr_select #(.N(NUM_REQ), .IW(IW)) u_sel (
    .req(req),
    .ptr(rr_ptr),
    .gnt(sel_gnt),
    .idx(sel_idx),
    .any(sel_any)
  );
  always_comb begin
    vin = 1'b0;
    din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        vin = in_valid[i];
        din = in_data[8*i +: 8];
      end
    end
  end
  assign gnext = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
  assign last = byte_cnt == CNT_W'(MAX_LEN - 1);
  assign short_frame = byte_cnt < CNT_W'(MIN_LEN);
  assign pad_done = byte_cnt == CNT_W'(MIN_LEN);
  assign expired = timer == TW'(TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else state <= next;
  end
  always_comb begin
    next = ST_IDLE;
    case (state)
      ST_IDLE:  next = (!tx_active && sel_any) ? ST_GRANT : ST_IDLE;
      ST_GRANT: next = vin ? ST_SEND : expired ? ST_IDLE : ST_GRANT;
      ST_SEND:  next = vin ? (last ? ST_WAIT : ST_SEND) : short_frame ? ST_PAD : ST_WAIT;
      ST_PAD:   next = pad_done ? ST_WAIT : ST_PAD;
      ST_WAIT:  next = (seen && !tx_active) ? ST_IDLE : ST_WAIT;
      default:  next = ST_IDLE;
    endcase
  end
  always_comb busy = state != ST_IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      grant <= '0;
      gidx <= '0;
      rr_ptr <= '0;
      tx_data <= '0;
      tx_enable <= 1'b0;
      byte_cnt <= '0;
      timer <= '0;
      seen <= 1'b0;
      truncated <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      truncated <= 1'b0;
      timed_out <= 1'b0;
      // tx_active lags tx_enable, so remember it was seen before trusting a low level
      seen <= (state != ST_IDLE) && (seen || tx_active);
      case (state)
        ST_IDLE: if (!tx_active && sel_any) begin
          grant <= sel_gnt;
          gidx <= sel_idx;
          byte_cnt <= '0;
          timer <= '0;
        end
        ST_GRANT: if (vin) begin
          tx_data <= din;
          tx_enable <= 1'b1;
          byte_cnt <= CNT_W'(1);
        end else begin
          timer <= timer + TW'(1);
          if (expired) begin
            grant <= '0;
            timed_out <= 1'b1;
            rr_ptr <= gnext;
          end
        end
        ST_SEND: if (vin) begin
          tx_data <= din;
          tx_enable <= 1'b1;
          byte_cnt <= byte_cnt + CNT_W'(1);
          if (last) begin
            grant <= '0;
            truncated <= 1'b1;
          end
        end else begin
          // a short frame emits its first pad byte here so tx_enable stays contiguous
          grant <= '0;
          tx_data <= '0;
          tx_enable <= short_frame;
          byte_cnt <= short_frame ? byte_cnt + CNT_W'(1) : byte_cnt;
        end
        ST_PAD: begin
          tx_data <= '0;
          tx_enable <= !pad_done;
          byte_cnt <= pad_done ? byte_cnt : byte_cnt + CNT_W'(1);
        end
        ST_WAIT: begin
          tx_data <= '0;
          tx_enable <= 1'b0;
          rr_ptr <= gnext;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed checks of grant order, padding, truncation, timeout and reset
module tb_eth_tx_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic [2:0] req = '0, grant, in_valid = '0;
  logic [23:0] in_data = '0;
  logic [7:0] tx_data;
  logic tx_enable, busy, truncated, timed_out;
  logic tx_active = 1'b0;
  int gap = 0;
  int tests = 0, fails = 0;
  int len[3] = '{0, 0, 0};
  int cnt[3] = '{0, 0, 0};
  logic [7:0] base[3] = '{8'h00, 8'h00, 8'h00};
  bit mute[3] = '{0, 0, 0};
  bit noise = 0;
  logic [2:0] gp = '0;
  logic [7:0] frame[$];
  logic [2:0] glog[$];
  int cyc = 0, rises = 0, trunc_n = 0, to_n = 0, viol = 0, min_gap = 1000;
  int en_rise_cyc = 0, en_fall_cyc = 0, grise_cyc = 0, gfall_cyc = 0, vfall_cyc = 0;
  bit en_fall_seen = 0, en_prev = 0, b_prev = 0, act_prev = 0, v1_prev = 0;
  logic [2:0] g_prev = '0;
  int err;

  eth_tx_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .grant(grant), .in_valid(in_valid),
    .in_data(in_data), .tx_data(tx_data), .tx_enable(tx_enable), .tx_active(tx_active),
    .busy(busy), .truncated(truncated), .timed_out(timed_out)
  );

  always #4 clock = ~clock;

  // sender model: busy from the cycle after tx_enable until 12 cycles after it drops
  always @(posedge clock) begin
    if (tx_enable) gap <= 12;
    else if (gap != 0) gap <= gap - 1;
    tx_active <= tx_enable || gap != 0;
  end

  // frame sources: stream len bytes of base+n once granted
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (grant[i] && !gp[i]) cnt[i] = 0;
      if (grant[i] && !mute[i] && cnt[i] < len[i]) begin
        in_valid[i] = 1'b1;
        in_data[8*i +: 8] = 8'(int'(base[i]) + cnt[i]);
        cnt[i]++;
      end else if (!grant[i] && noise && i == 2) begin
        in_valid[i] = 1'b1;
        in_data[8*i +: 8] = 8'hEE;
      end else begin
        in_valid[i] = 1'b0;
        in_data[8*i +: 8] = 8'h00;
      end
    end
    gp = grant;
  end

  always @(posedge clock) begin
    #1;
    cyc++;
    if (tx_enable) frame.push_back(tx_data);
    if (tx_enable && !en_prev) begin
      rises++;
      en_rise_cyc = cyc;
      if (en_fall_seen && cyc - en_fall_cyc < min_gap) min_gap = cyc - en_fall_cyc;
    end
    if (!tx_enable && en_prev) begin
      en_fall_cyc = cyc;
      en_fall_seen = 1;
    end
    if (grant != 0 && g_prev == 0) begin
      glog.push_back(grant);
      grise_cyc = cyc;
      if (act_prev) viol++;
    end
    if (grant == 0 && g_prev != 0) gfall_cyc = cyc;
    if (!in_valid[1] && v1_prev) vfall_cyc = cyc;
    if (!busy && b_prev && act_prev && !reset) viol++;
    if (!$onehot0(grant)) viol++;
    if (truncated) trunc_n++;
    if (timed_out) to_n++;
    en_prev = tx_enable;
    b_prev = busy;
    act_prev = tx_active;
    v1_prev = in_valid[1];
    g_prev = grant;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    frame.delete();
    glog.delete();
    rises = 0;
    trunc_n = 0;
    to_n = 0;
    min_gap = 1000;
    en_fall_seen = 0;
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int n = 0;
    while (grant == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_truncated", truncated, 0);
    chk("rst_timed_out", timed_out, 0);
    reset = 1'b0;
    @(negedge clock);

    // 64-byte frame from source 0 while idle source 2 drives noise
    clr();
    len[0] = 64; base[0] = 8'h01; noise = 1;
    req[0] = 1'b1;
    @(negedge clock);
    chk("t1_grant", grant, 3'b001);
    req[0] = 1'b0;
    wait_idle("t1_idle", 400);
    noise = 0;
    chk("t1_len", frame.size(), 64);
    chk("t1_rises", rises, 1);
    err = 0;
    for (int i = 0; i < 64; i++) if (frame[i] !== 8'(i + 1)) err++;
    chk("t1_data", err, 0);
    chk("t1_latency", en_rise_cyc - grise_cyc, 1);

    // 10-byte frame from source 1 padded to 60
    clr();
    len[1] = 10; base[1] = 8'h81;
    req[1] = 1'b1;
    wait_grant("t2_wait", 40);
    chk("t2_grant", grant, 3'b010);
    req[1] = 1'b0;
    wait_idle("t2_idle", 400);
    chk("t2_len", frame.size(), 60);
    chk("t2_rises", rises, 1);
    err = 0;
    for (int i = 0; i < 60; i++) if (frame[i] !== ((i < 10) ? 8'(8'h81 + i) : 8'h00)) err++;
    chk("t2_data", err, 0);
    chk("t2_grant_drop", gfall_cyc, vfall_cyc);

    // source 2 granted but silent: withdrawn after 16 cycles
    clr();
    mute[2] = 1; req[2] = 1'b1;
    wait_grant("t4_wait", 40);
    chk("t4_grant", grant, 3'b100);
    req[2] = 1'b0;
    wait_idle("t4_idle", 60);
    chk("t4_hold", gfall_cyc - grise_cyc, 16);
    chk("t4_timed_out", to_n, 1);
    chk("t4_rises", rises, 0);
    mute[2] = 0;

    // all three request continuously; timeout left rr_ptr at 0
    clr();
    len = '{60, 60, 60}; base = '{8'h10, 8'h20, 8'h30};
    req = 3'b111;
    for (int n = 0; n < 1000 && glog.size() < 4; n++) @(negedge clock);
    chk("t3_ngrants", glog.size(), 4);
    req = 3'b000;
    wait_idle("t3_idle", 500);
    chk("t3_g0", glog[0], 3'b001);
    chk("t3_g1", glog[1], 3'b010);
    chk("t3_g2", glog[2], 3'b100);
    chk("t3_g3", glog[3], 3'b001);
    chk("t3_rises", rises, 4);
    chk("t3_len", frame.size(), 240);
    chk("t3_f1", frame[60], 8'h20);
    chk("t3_f2", frame[120], 8'h30);
    chk("t3_f3", frame[180], 8'h10);
    chk("t3_gap", 64'(min_gap >= 12 && min_gap < 1000), 64'd1);

    // 2000-byte frame truncated to 1514
    clr();
    len[0] = 2000; base[0] = 8'h00;
    req[0] = 1'b1;
    wait_grant("t5_wait", 40);
    req[0] = 1'b0;
    wait_idle("t5_idle", 2500);
    chk("t5_len", frame.size(), 1514);
    chk("t5_last", frame[1513], 8'hE9);
    chk("t5_rises", rises, 1);
    chk("t5_truncated", trunc_n, 1);

    // reset at byte 30, then both 0 and 1 request
    clr();
    len[1] = 100; base[1] = 8'h40;
    req[1] = 1'b1;
    wait_grant("t6_wait", 40);
    chk("t6_grant", grant, 3'b010);
    req[1] = 1'b0;
    for (int n = 0; n < 100 && frame.size() < 30; n++) @(negedge clock);
    chk("t6_midframe", frame.size(), 30);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_enable", tx_enable, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    reset = 1'b0;
    clr();
    len[0] = 5; base[0] = 8'hA0;
    req = 3'b011;
    wait_grant("t6_regrant_wait", 100);
    chk("t6_regrant", grant, 3'b001);
    req = 3'b000;
    wait_idle("t6_idle", 400);
    chk("t6_len", frame.size(), 60);
    chk("t6_b4", frame[4], 8'hA4);
    chk("t6_pad", frame[5], 8'h00);
    chk("protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single RGMII transmit path between NUM_REQ frame sources, e.g. ARP reply, ICMP echo and UDP data.
- Grants access round-robin and streams the granted source's bytes onto the sender's data/tx_enable inputs.
- Zero-pads short frames up to MIN_LEN bytes and truncates frames that exceed MAX_LEN.
- Holds off the next grant until the sender reports it is idle, so the sender's preamble insertion and inter-frame gap are never violated.

Parameters:
- NUM_REQ, 3, number of requesting sources (2..8).
- MIN_LEN, 60, minimum payload bytes per frame; shorter frames are padded with 8'h00.
- MAX_LEN, 1514, maximum payload bytes; longer frames are truncated.
- TIMEOUT, 16, cycles a granted source may take to raise in_valid before its grant is withdrawn.

Ports:
- clock  in  1  125 MHz transmit clock, the same clock as the sender's byte interface.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per source; held until grant is seen.
- grant  out  NUM_REQ  one-hot grant; at most one bit set.
- in_valid  in  NUM_REQ  per-source byte valid; must be contiguous for one frame.
- in_data  in  8*NUM_REQ  per-source byte; source i occupies bits [8i+7:8i].
- tx_data  out  8  byte to the sender.
- tx_enable  out  1  frame enable to the sender; contiguous for the whole frame.
- tx_active  in  1  sender busy, covering frame, shift-register purge and inter-frame gap.
- busy  out  1  high in any state other than IDLE.
- truncated  out  1  one-cycle pulse when a frame is cut at MAX_LEN.
- timed_out  out  1  one-cycle pulse when a grant is withdrawn by timeout.

Behaviour:
- Reset: grant=0, tx_enable=0, tx_data=0, busy=0, truncated=0, timed_out=0; state=IDLE; rr_ptr=0; byte_cnt=0; timer=0. Reset mid-frame drops tx_enable on the next edge. The sender then sees a short, runt frame; this is accepted.
- States: IDLE, GRANT, SEND, PAD, WAIT_IDLE.

IDLE:
- Runs only when tx_active=0.
- Selects the first source with req set, searching from rr_ptr upward with wrap-around.
- Registers grant one-hot, clears byte_cnt and timer, and moves to GRANT.
- Grant appears one cycle after req is sampled.

GRANT:
- If in_valid[g]=1: tx_data<=in_data[g], tx_enable<=1, byte_cnt<=1, and the state moves to SEND.
- Else timer increments. When timer==TIMEOUT-1: grant<=0, timed_out pulses, rr_ptr<=g+1 (mod NUM_REQ), and the state returns to IDLE.

SEND:
- While in_valid[g]=1: tx_data<=in_data[g], tx_enable<=1, byte_cnt++.
- When a byte is accepted with byte_cnt==MAX_LEN-1, that byte is the last one. Then grant<=0, truncated pulses, and the state moves to WAIT_IDLE. tx_enable drops on the following cycle.
- When in_valid[g] falls:
  - If byte_cnt<MIN_LEN, go to PAD. grant drops now.
  - Else tx_enable<=0, grant<=0, go to WAIT_IDLE.

PAD:
- tx_data<=0 and tx_enable<=1 until byte_cnt==MIN_LEN, then tx_enable<=0 and go to WAIT_IDLE.

WAIT_IDLE:
- rr_ptr<=g+1.
- Waits until tx_active has been seen high and is then low, then goes to IDLE.
- The seen-high flag guards against the one-cycle lag between tx_enable and tx_active.

General rules:
- Latency: in_data to tx_data is exactly 1 cycle; tx_enable is aligned with tx_data.
- in_valid and in_data from non-granted sources are ignored.
- A req deassert during SEND is ignored; in_valid alone delimits the frame.
- A source whose req is still high after WAIT_IDLE competes normally and gets no priority boost.
- byte_cnt is 11 bits and never exceeds MAX_LEN.
- Simultaneous requests are resolved purely by rr_ptr order.

Decomposition:
- Shared package eth_tx_pkg holds: the state encoding (one-hot localparams ST_IDLE/ST_GRANT/ST_SEND/ST_PAD/ST_WAIT); ETH_MIN_PAYLOAD=60; ETH_MAX_PAYLOAD=1514; the byte-count width constant.
- One natural sub-module: rr_select. It is a combinational round-robin priority picker that takes req and rr_ptr and returns a one-hot grant plus an encoded index.

Test Plan:
1. Single 64-byte frame, source 0, bytes 0x01..0x40 → grant[0] one cycle after req; tx_enable high for 64 contiguous cycles; tx_data = in_data delayed by 1; tx_active handshake respected; busy falls after tx_active falls.
2. 10-byte frame from source 1 → 10 payload bytes then 50 bytes of 0x00; tx_enable high for 60 cycles; grant drops when in_valid falls.
3. All three reqs asserted continuously, each sending 60 bytes → grant order 0,1,2,0; no new grant while tx_active=1; gap between frames ≥ the sender's gap.
4. Source 2 granted and never raises in_valid → grant withdrawn after 16 cycles; timed_out pulses once; tx_enable never rises; next grant goes to source 0.
5. Source 0 streams 2000 bytes → exactly 1514 bytes sent; truncated pulses once; bytes after the cut are ignored.
6. Reset asserted at byte 30 of a frame → next cycle tx_enable=0 and grant=0; state is IDLE; a new req is granted once tx_active goes low.
